// File: rtl/round_sequencer.sv
// Round sequencer: loads a state word into slice memory, runs it through the
// enabled stage units for a fixed number of rounds, then unloads it.
module round_sequencer #(
  parameter int NUM_STAGES = 5,
  parameter int SLICES     = 64,
  parameter int ROUNDS     = 24,
  localparam int SW = $clog2(SLICES),
  localparam int RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1,
  localparam int XW = $clog2(NUM_STAGES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [NUM_STAGES-1:0] stage_mask,
  input  logic                  in_valid,
  input  logic                  out_ack,
  input  logic [NUM_STAGES-1:0] stg_ready,
  input  logic [NUM_STAGES-1:0] stg_put_input,
  input  logic [NUM_STAGES-1:0] stg_out_ready,
  output logic                  ready,
  output logic                  in_req,
  output logic                  out_valid,
  output logic                  done,
  output logic                  aborted,
  output logic [NUM_STAGES-1:0] stg_start,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [SW-1:0]         mem_addr,
  output logic [XW-1:0]         mem_src,
  output logic [XW-1:0]         stage_idx,
  output logic [RW-1:0]         round_idx
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_LOAD      = 4'd1,
    S_WAIT_RDY  = 4'd2,
    S_START     = 4'd3,
    S_WAIT_IN   = 4'd4,
    S_FEED      = 4'd5,
    S_WAIT_OUT  = 4'd6,
    S_WB        = 4'd7,
    S_ROUND_END = 4'd8,
    S_UNLOAD    = 4'd9,
    S_DONE      = 4'd10
  } state_t;

  localparam logic [SW-1:0] SLICE_LAST = SW'(SLICES - 1);
  localparam logic [RW-1:0] ROUND_LAST = RW'(ROUNDS - 1);

  state_t                  state;
  logic [SW-1:0]           slice;
  logic [RW-1:0]           round;
  logic [XW-1:0]           stage;
  logic [NUM_STAGES-1:0]   mask;
  logic                    abort_seen;

  logic [NUM_STAGES-1:0]   sel;
  logic                    sel_ready;
  logic                    sel_put;
  logic                    sel_out;
  logic [XW:0]             first_stage;
  logic [XW:0]             next_stage;

  // Lowest enabled stage at or above 'from'; MSB flags that one was found.
  function automatic logic [XW:0] find_enabled(input logic [NUM_STAGES-1:0] m,
                                               input logic [XW-1:0] from);
    logic [XW:0] r;
    r = {(XW + 1){1'b0}};
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (m[i] && (XW'(i) >= from)) begin
        r = {1'b1, XW'(i)};
      end
    end
    return r;
  endfunction

  // One-hot select of the current stage and its qualified handshakes
  always_comb begin
    for (int i = 0; i < NUM_STAGES; i++) begin
      sel[i] = (stage == XW'(i));
    end
    sel_ready   = |(stg_ready & sel);
    sel_put     = |(stg_put_input & sel);
    sel_out     = |(stg_out_ready & sel);
    first_stage = find_enabled(mask, {XW{1'b0}});
    next_stage  = find_enabled(mask, stage + XW'(1));
  end

  // Sequencer state, counters and latched stage mask
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      slice      <= {SW{1'b0}};
      round      <= {RW{1'b0}};
      stage      <= {XW{1'b0}};
      mask       <= {NUM_STAGES{1'b0}};
      abort_seen <= 1'b0;
    end else begin
      abort_seen <= 1'b0;
      if (abort && (state != S_IDLE)) begin
        state      <= S_IDLE;
        slice      <= {SW{1'b0}};
        round      <= {RW{1'b0}};
        stage      <= {XW{1'b0}};
        abort_seen <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              state <= S_LOAD;
              mask  <= stage_mask;
              slice <= {SW{1'b0}};
              round <= {RW{1'b0}};
              stage <= {XW{1'b0}};
            end
          end
          S_LOAD: begin
            if (in_valid) begin
              if (slice == SLICE_LAST) begin
                slice <= {SW{1'b0}};
                if (first_stage[XW]) begin
                  stage <= first_stage[XW-1:0];
                  state <= S_WAIT_RDY;
                end else begin
                  state <= S_ROUND_END;
                end
              end else begin
                slice <= slice + SW'(1);
              end
            end
          end
          S_WAIT_RDY: begin
            if (sel_ready) begin
              state <= S_START;
            end
          end
          S_START: begin
            slice <= {SW{1'b0}};
            state <= S_WAIT_IN;
          end
          S_WAIT_IN: begin
            if (sel_put) begin
              state <= S_FEED;
            end
          end
          S_FEED: begin
            if (sel_put) begin
              if (slice == SLICE_LAST) begin
                slice <= {SW{1'b0}};
                state <= S_WAIT_OUT;
              end else begin
                slice <= slice + SW'(1);
              end
            end
          end
          S_WAIT_OUT: begin
            slice <= {SW{1'b0}};
            if (sel_out) begin
              state <= S_WB;
            end
          end
          S_WB: begin
            if (slice == SLICE_LAST) begin
              slice <= {SW{1'b0}};
              if (next_stage[XW]) begin
                stage <= next_stage[XW-1:0];
                state <= S_WAIT_RDY;
              end else begin
                state <= S_ROUND_END;
              end
            end else begin
              slice <= slice + SW'(1);
            end
          end
          S_ROUND_END: begin
            if (round == ROUND_LAST) begin
              slice <= {SW{1'b0}};
              state <= S_UNLOAD;
            end else begin
              round <= round + RW'(1);
              // An all-zero mask simply idles one cycle per round here.
              if (first_stage[XW]) begin
                stage <= first_stage[XW-1:0];
                state <= S_WAIT_RDY;
              end else begin
                state <= S_ROUND_END;
              end
            end
          end
          S_UNLOAD: begin
            if (out_ack) begin
              if (slice == SLICE_LAST) begin
                slice <= {SW{1'b0}};
                state <= S_DONE;
              end else begin
                slice <= slice + SW'(1);
              end
            end
          end
          S_DONE: begin
            state <= S_IDLE;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

  // Output decode from state and counters; strobes qualified by the live handshake
  always_comb begin
    ready     = 1'b0;
    in_req    = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    stg_start = {NUM_STAGES{1'b0}};
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_src   = {XW{1'b0}};
    case (state)
      S_IDLE: begin
        ready = 1'b1;
      end
      S_LOAD: begin
        in_req    = 1'b1;
        mem_write = in_valid;
      end
      S_START: begin
        stg_start = sel;
      end
      S_FEED: begin
        mem_read = sel_put;
      end
      S_WB: begin
        mem_write = 1'b1;
        mem_src   = stage + XW'(1);
      end
      S_UNLOAD: begin
        out_valid = 1'b1;
        mem_read  = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        ready = 1'b0;
      end
    endcase
    aborted   = abort_seen;
    mem_addr  = slice;
    stage_idx = stage;
    round_idx = round;
  end

endmodule

// File: tb/tb_round_sequencer.sv
// Scoreboard bench for round_sequencer (3 stages, 4 slices, 2 rounds): expected
// memory/stage events are queued by the stimulus and popped by a monitor.
module tb_round_sequencer;
  localparam int NS = 3;
  localparam int SL = 4;
  localparam int RN = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, abort, in_valid, out_ack;
  logic [NS-1:0] stage_mask, stg_ready, stg_put_input, stg_out_ready, put_val;
  logic          toggle_en;
  logic          tog = 1'b0;
  logic          ready, in_req, out_valid, done, aborted, mem_read, mem_write;
  logic [NS-1:0] stg_start;
  logic [1:0]    mem_addr, mem_src, stage_idx;
  logic          round_idx;

  int total = 0;
  int bad = 0;
  int reads_seen = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  round_sequencer #(.NUM_STAGES(NS), .SLICES(SL), .ROUNDS(RN)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .stage_mask(stage_mask),
    .in_valid(in_valid), .out_ack(out_ack), .stg_ready(stg_ready),
    .stg_put_input(stg_put_input), .stg_out_ready(stg_out_ready),
    .ready(ready), .in_req(in_req), .out_valid(out_valid), .done(done),
    .aborted(aborted), .stg_start(stg_start), .mem_read(mem_read),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_src(mem_src),
    .stage_idx(stage_idx), .round_idx(round_idx)
  );

  assign stg_put_input = toggle_en ? {NS{tog}} : put_val;

  // put_input alternates every cycle when enabled, changing away from both edges
  always begin
    @(posedge clk);
    #1 tog = ~tog;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Event word: kind (1 W, 2 R, 3 S, 4 O, 5 D, 6 A), field a, field b, round
  function automatic logic [31:0] ev(input int k, input int a, input int b, input int r);
    return {8'(k), 8'(a), 8'(b), 8'(r)};
  endfunction

  task automatic sb(input logic [31:0] e);
    if (exp_q.size() == 0) chk("unexpected_event", e, 32'h0);
    else chk("sb_event", e, exp_q.pop_front());
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (mem_write) sb(ev(1, int'(mem_addr), int'(mem_src), int'(round_idx)));
      if (mem_read && !out_valid) begin
        sb(ev(2, int'(mem_addr), int'(stage_idx), int'(round_idx)));
        reads_seen++;
      end
      if (|stg_start) sb(ev(3, int'(stage_idx), int'(stg_start), int'(round_idx)));
      if (out_valid && out_ack) sb(ev(4, int'(mem_addr), 0, 0));
      if (done) sb(ev(5, 0, 0, 0));
      if (aborted) sb(ev(6, 0, 0, 0));
    end
  end

  task automatic push_stage(input int s, input int r, input int nw);
    exp_q.push_back(ev(3, s, 1 << s, r));
    for (int i = 0; i < SL; i++) exp_q.push_back(ev(2, i, s, r));
    for (int i = 0; i < nw; i++) exp_q.push_back(ev(1, i, s + 1, r));
  endtask

  task automatic push_loads();
    for (int i = 0; i < SL; i++) exp_q.push_back(ev(1, i, 0, 0));
  endtask

  task automatic push_run(input logic [NS-1:0] m);
    push_loads();
    for (int r = 0; r < RN; r++)
      for (int s = 0; s < NS; s++)
        if (m[s]) push_stage(s, r, SL);
    for (int i = 0; i < SL; i++) exp_q.push_back(ev(4, i, 0, 0));
    exp_q.push_back(ev(5, 0, 0, 0));
  endtask

  task automatic start_op(input logic [NS-1:0] m);
    stage_mask = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input string name);
    bit seen = 1'b0;
    for (int c = 0; c < 3000 && !seen; c++) begin
      @(negedge clk);
      if (done || aborted) seen = 1'b1;
    end
    if (!seen) chk({name, "_timeout"}, 32'd0, 32'd1);
    @(negedge clk);
    chk({name, "_ready_after"}, 32'(ready), 32'd1);
    chk({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int r0, lat;
    bit hit;
    rst = 1'b1; start = 1'b0; abort = 1'b0; stage_mask = '0;
    in_valid = 1'b1; out_ack = 1'b1; toggle_en = 1'b0;
    stg_ready = '1; stg_out_ready = '1; put_val = '1;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_strobes", {27'd0, in_req, out_valid, done, aborted, mem_write}, 32'd0);
    chk("rst_start_read", {28'd0, stg_start, mem_read}, 32'd0);
    chk("rst_counters", {25'd0, mem_addr, mem_src, stage_idx, round_idx}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // full mask, everything ready
    push_run(3'b111);
    start_op(3'b111);
    wait_end("full_mask");

    // single stage; mask change and stray start after start are ignored
    push_run(3'b010);
    start_op(3'b010);
    stage_mask = 3'b111;
    repeat (10) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_end("mask_010");

    // put_input alternating during FEED
    r0 = reads_seen;
    toggle_en = 1'b1;
    push_run(3'b001);
    start_op(3'b001);
    wait_end("toggle");
    chk("toggle_feed_reads", 32'(reads_seen - r0), 32'd8);
    toggle_en = 1'b0;

    // abort during write-back of round 1, stage 2
    push_loads();
    for (int s = 0; s < NS; s++) push_stage(s, 0, SL);
    push_stage(0, 1, SL);
    push_stage(1, 1, SL);
    push_stage(2, 1, 1);
    start_op(3'b111);
    hit = 1'b0;
    for (int c = 0; c < 3000 && !hit; c++) begin
      if (mem_write && mem_src == 2'd3 && round_idx == 1'b1) hit = 1'b1;
      else @(negedge clk);
    end
    if (!hit) chk("abort_reach_wb", 32'd0, 32'd1);
    abort = 1'b1;
    exp_q.push_back(ev(6, 0, 0, 0));
    @(negedge clk);
    abort = 1'b0;
    chk("abort_pulse", 32'(aborted), 32'd1);
    chk("abort_no_done", 32'(done), 32'd0);
    chk("abort_ready", 32'(ready), 32'd1);
    @(negedge clk);
    chk("abort_pulse_clear", 32'(aborted), 32'd0);
    chk("abort_queue_empty", 32'(exp_q.size()), 32'd0);
    push_run(3'b111);
    start_op(3'b111);
    wait_end("after_abort");

    // asynchronous reset during FEED
    push_loads();
    exp_q.push_back(ev(3, 0, 1, 0));
    exp_q.push_back(ev(2, 0, 0, 0));
    start_op(3'b111);
    hit = 1'b0;
    for (int c = 0; c < 3000 && !hit; c++) begin
      if (mem_read && !out_valid) hit = 1'b1;
      else @(negedge clk);
    end
    if (!hit) chk("rst_reach_feed", 32'd0, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("midrst_ready", 32'(ready), 32'd1);
    chk("midrst_strobes", {26'd0, in_req, out_valid, mem_read, mem_write, done, aborted}, 32'd0);
    chk("midrst_start", 32'(stg_start), 32'd0);
    chk("midrst_counters", {25'd0, mem_addr, mem_src, stage_idx, round_idx}, 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    chk("midrst_queue_empty", 32'(exp_q.size()), 32'd0);
    @(negedge clk);

    // zero mask: loads, two idle rounds, unload
    push_run(3'b000);
    start_op(3'b000);
    hit = 1'b0;
    for (int c = 0; c < 3000 && !hit; c++) begin
      if (mem_write && mem_addr == 2'd3) hit = 1'b1;
      else @(negedge clk);
    end
    lat = 0;
    for (int c = 0; c < 20 && !out_valid; c++) begin
      @(negedge clk);
      lat++;
    end
    chk("mask0_round_end_latency", 32'(lat), 32'd3);
    wait_end("mask0");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
